// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg
// Shared constants, sizing helpers and FSM encoding for the partial-sum
// accumulator slice. Optional build macro used by this slice: PSUM_SATURATE_EN.
// No ports (package).

package psum_accumulator_pkg;

    localparam int unsigned DEFAULT_NOUT      = 3;
    localparam int unsigned DEFAULT_POUT      = 2;
    localparam int unsigned DEFAULT_BIT_WIDTH = 8;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single-row file still needs a one-bit address port.
    function automatic int unsigned addr_width(input int unsigned rows);
        return (clog2(rows) > 0) ? clog2(rows) : 1;
    endfunction

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

endpackage

// File: rtl/psum_lane_add.sv
// psum_lane_add
// One lane of the partial-sum adder: signed BIT_WIDTH add.
// Build macro PSUM_SATURATE_EN selects a saturating add; otherwise the sum wraps
// modulo 2^BIT_WIDTH and no overflow logic exists.
// Ports:
//   a   in  BIT_WIDTH  stored partial sum (or zero on a first beat)
//   b   in  BIT_WIDTH  new partial product
//   sum out BIT_WIDTH  lane result

module psum_lane_add #(
    parameter int unsigned BIT_WIDTH = 8
) (
    input  logic signed [BIT_WIDTH-1:0] a,
    input  logic signed [BIT_WIDTH-1:0] b,
    output logic signed [BIT_WIDTH-1:0] sum
);

`ifdef PSUM_SATURATE_EN
    localparam logic [BIT_WIDTH-1:0] MaxVal = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] MinVal = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    logic [BIT_WIDTH:0] wide;

    always_comb begin
        wide = {a[BIT_WIDTH-1], a} + {b[BIT_WIDTH-1], b};
        // Top two bits disagree only on signed overflow; the top bit gives direction.
        if (wide[BIT_WIDTH] != wide[BIT_WIDTH-1]) begin
            sum = wide[BIT_WIDTH] ? MinVal : MaxVal;
        end else begin
            sum = wide[BIT_WIDTH-1:0];
        end
    end
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator
// Read-modify-write controller in front of the partial-sum register file.
// Zeroes every row after reset or on clear_req, then accumulates one beat of
// Pout lanes per cycle: read at accept, add and write back one cycle later.
// Build macro PSUM_SATURATE_EN (see psum_lane_add) selects saturating adds.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready                beat handshake
//   in_addr/in_data/in_first/in_last beat row, lanes, start and end of row
//   clear_req                        zero all rows (honoured in RUN only)
//   rf_read_en/rf_read_addr          register file read port request
//   rf_read_data                     register file read data, 1 cycle later
//   rf_write_en/addr/data            register file write port
//   row_done/row_done_addr           pulse when a last beat has been written
//   clear_busy                       high while zeroing

module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter  int unsigned Nout      = DEFAULT_NOUT,
    parameter  int unsigned Pout      = DEFAULT_POUT,
    parameter  int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH,
    localparam int unsigned NADDR     = ceil_div(Nout, Pout),
    localparam int unsigned ADDR_W    = addr_width(NADDR)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [Pout*BIT_WIDTH-1:0] in_data,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic                      clear_req,
    output logic                      rf_read_en,
    output logic [ADDR_W-1:0]         rf_read_addr,
    input  logic [Pout*BIT_WIDTH-1:0] rf_read_data,
    output logic                      rf_write_en,
    output logic [ADDR_W-1:0]         rf_write_addr,
    output logic [Pout*BIT_WIDTH-1:0] rf_write_data,
    output logic                      row_done,
    output logic [ADDR_W-1:0]         row_done_addr,
    output logic                      clear_busy
);

    localparam int unsigned      DW      = Pout * BIT_WIDTH;
    localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(NADDR - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                s1_valid_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [DW-1:0]       s1_data_q;
    logic                s1_first_q;
    logic                s1_last_q;
    logic                row_done_q;
    logic [ADDR_W-1:0]   row_done_addr_q;

    logic                accept;
    logic                addr_ok;
    logic [DW-1:0]       sum_data;

    // Out-of-range rows can only exist when the row count is not a power of two.
    if ((32'd1 << ADDR_W) > NADDR) begin : g_range_chk
        assign addr_ok = (32'(in_addr) < NADDR);
    end else begin : g_range_full
        assign addr_ok = 1'b1;
    end

    // Dropping ready with clear_req guarantees the write port is idle once CLEAR starts.
    assign in_ready     = (state_q == StRun) && !clear_req;
    assign accept       = in_valid && in_ready;
    assign rf_read_en   = accept && !in_first && addr_ok;
    assign rf_read_addr = in_addr;
    assign clear_busy   = (state_q == StClear);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StClear;
            cnt_q           <= '0;
            s1_valid_q      <= 1'b0;
            row_done_q      <= 1'b0;
            row_done_addr_q <= '0;
        end else begin
            case (state_q)
                StClear: begin
                    if (cnt_q == LastRow) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                StRun: begin
                    if (clear_req) begin
                        state_q <= StClear;
                    end
                end
            endcase
            s1_valid_q <= accept && addr_ok;
            row_done_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q && s1_last_q) begin
                row_done_addr_q <= s1_addr_q;
            end
        end
    end

    // Payload registers need no reset: s1_valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr_q  <= in_addr;
            s1_data_q  <= in_data;
            s1_first_q <= in_first;
            s1_last_q  <= in_last;
        end
    end

    for (genvar i = 0; i < Pout; i++) begin : g_lane
        logic [BIT_WIDTH-1:0] old_val;
        assign old_val = s1_first_q ? '0 : rf_read_data[i*BIT_WIDTH +: BIT_WIDTH];
        psum_lane_add #(
            .BIT_WIDTH(BIT_WIDTH)
        ) u_add (
            .a  (old_val),
            .b  (s1_data_q[i*BIT_WIDTH +: BIT_WIDTH]),
            .sum(sum_data[i*BIT_WIDTH +: BIT_WIDTH])
        );
    end

    // Writes are suppressed during reset so an in-flight beat never lands.
    always_comb begin
        rf_write_en   = 1'b0;
        rf_write_addr = s1_addr_q;
        rf_write_data = sum_data;
        if (state_q == StClear) begin
            rf_write_en   = !rst;
            rf_write_addr = cnt_q;
            rf_write_data = '0;
        end else begin
            rf_write_en = s1_valid_q && !rst;
        end
    end

    assign row_done      = row_done_q;
    assign row_done_addr = row_done_addr_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
// Directed bench for psum_accumulator (Nout=3, Pout=2, BIT_WIDTH=8) against a
// behavioural register file with write-to-read forwarding, plus a second
// instance (Nout=5) whose row count leaves an unused address.
// Expected sums follow PSUM_SATURATE_EN when the bench is built with it.

module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_first, in_last, clear_req;
    logic [0:0]  in_addr;
    logic [15:0] in_data;
    logic        rf_read_en, rf_write_en;
    logic [0:0]  rf_read_addr, rf_write_addr;
    logic [15:0] rf_read_data, rf_write_data;
    logic        row_done, clear_busy;
    logic [0:0]  row_done_addr;

    logic        b_in_valid, b_in_ready, b_in_first, b_in_last;
    logic [1:0]  b_in_addr;
    logic [15:0] b_in_data;
    logic        b_rf_read_en, b_rf_write_en;
    logic [1:0]  b_rf_read_addr, b_rf_write_addr;
    logic [15:0] b_rf_read_data, b_rf_write_data;
    logic        b_row_done, b_clear_busy;
    logic [1:0]  b_row_done_addr;

    logic [15:0] mem [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psum_accumulator #(.Nout(3), .Pout(2), .BIT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_first(in_first), .in_last(in_last),
        .clear_req(clear_req), .rf_read_en(rf_read_en), .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data), .rf_write_en(rf_write_en),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .row_done(row_done), .row_done_addr(row_done_addr), .clear_busy(clear_busy)
    );

    psum_accumulator #(.Nout(5), .Pout(2), .BIT_WIDTH(8)) u_dut_odd (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_addr(b_in_addr), .in_data(b_in_data), .in_first(b_in_first),
        .in_last(b_in_last), .clear_req(1'b0), .rf_read_en(b_rf_read_en),
        .rf_read_addr(b_rf_read_addr), .rf_read_data(b_rf_read_data),
        .rf_write_en(b_rf_write_en), .rf_write_addr(b_rf_write_addr),
        .rf_write_data(b_rf_write_data), .row_done(b_row_done),
        .row_done_addr(b_row_done_addr), .clear_busy(b_clear_busy)
    );

    // Register file model: registered read, forwards a same-cycle write.
    always @(posedge clk) begin
        if (rf_read_en) begin
            rf_read_data <= (rf_write_en && rf_write_addr == rf_read_addr) ? rf_write_data
                                                                          : mem[rf_read_addr];
        end
        if (rf_write_en) begin
            mem[rf_write_addr] <= rf_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic beat(input logic v, input logic [0:0] a, input logic [15:0] d,
                        input logic f, input logic l);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        in_first = f;
        in_last  = l;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_req = 1'b0;
        beat(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        b_in_valid = 1'b0; b_in_addr = 2'd0; b_in_data = '0;
        b_in_first = 1'b0; b_in_last = 1'b0; b_rf_read_data = '0;

        // Post-reset clear: two zero writes, ready held low
        tick(); tick();
        rst = 1'b0;
        mid();
        check("rst_busy", 32'(clear_busy), 32'd1);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("clr0_we", 32'(rf_write_en), 32'd1);
        check("clr0_addr", 32'(rf_write_addr), 32'd0);
        check("clr0_data", 32'(rf_write_data), 32'd0);
        check("rst_rowdone", 32'(row_done), 32'd0);
        tick(); mid();
        check("clr1_we", 32'(rf_write_en), 32'd1);
        check("clr1_addr", 32'(rf_write_addr), 32'd1);
        check("clr1_ready", 32'(in_ready), 32'd0);
        tick(); mid();
        check("run_ready", 32'(in_ready), 32'd1);
        check("run_busy", 32'(clear_busy), 32'd0);
        check("run_we", 32'(rf_write_en), 32'd0);
        check("clr_mem0", 32'(mem[0]), 32'd0);
        check("clr_mem1", 32'(mem[1]), 32'd0);

        // Accumulate row 0: {3,5} first, {2,-1}, {1,1} last -> {6,5}
        tick(); beat(1'b1, 1'b0, 16'h0503, 1'b1, 1'b0); mid();
        check("acc_first_noread", 32'(rf_read_en), 32'd0);
        tick(); beat(1'b1, 1'b0, 16'hFF02, 1'b0, 1'b0); mid();
        check("acc_read_en", 32'(rf_read_en), 32'd1);
        check("acc_read_addr", 32'(rf_read_addr), 32'd0);
        check("acc_w1_en", 32'(rf_write_en), 32'd1);
        check("acc_w1_data", 32'(rf_write_data), 32'h0503);
        tick(); beat(1'b1, 1'b0, 16'h0101, 1'b0, 1'b1); mid();
        check("acc_w2_data", 32'(rf_write_data), 32'h0405);
        tick(); beat(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0); mid();
        check("acc_w3_data", 32'(rf_write_data), 32'h0506);
        check("acc_rowdone_early", 32'(row_done), 32'd0);
        tick(); mid();
        check("acc_rowdone", 32'(row_done), 32'd1);
        check("acc_rowdone_addr", 32'(row_done_addr), 32'd0);
        tick(); mid();
        check("acc_rowdone_pulse", 32'(row_done), 32'd0);
        check("acc_mem0", 32'(mem[0]), 32'h0506);

        // Same-address hazard; the row-1 beat is first+last (plain write)
        tick(); beat(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick(); beat(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
        tick(); beat(1'b1, 1'b1, 16'h0101, 1'b1, 1'b1);
        tick(); beat(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
        tick(); beat(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0); mid();
        check("haz_rowdone", 32'(row_done), 32'd1);
        check("haz_rowdone_addr", 32'(row_done_addr), 32'd1);
        tick(); beat(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0); mid();
        check("haz_rowdone_hold", 32'(row_done_addr), 32'd1);
        check("haz_rowdone_pulse", 32'(row_done), 32'd0);
        tick(); mid();
        check("haz_mem0", 32'(mem[0]), 32'h0303);
        check("haz_mem1", 32'(mem[1]), 32'h0101);

        // Overflow: lane0 100+100, lane1 -100+-100
        tick(); beat(1'b1, 1'b1, 16'h9C64, 1'b1, 1'b0);
        tick(); beat(1'b1, 1'b1, 16'h9C64, 1'b0, 1'b0);
        tick(); beat(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0); mid();
`ifdef PSUM_SATURATE_EN
        check("ovf_data", 32'(rf_write_data), 32'h807F);
        tick(); mid();
        check("ovf_mem1", 32'(mem[1]), 32'h807F);
`else
        check("ovf_data", 32'(rf_write_data), 32'h38C8);
        tick(); mid();
        check("ovf_mem1", 32'(mem[1]), 32'h38C8);
`endif

        // Clear mid-stream; a second clear_req inside CLEAR is ignored
        tick(); beat(1'b1, 1'b0, 16'h0707, 1'b1, 1'b0);
        tick(); clear_req = 1'b1; beat(1'b1, 1'b1, 16'h0505, 1'b1, 1'b0); mid();
        check("cm_ready", 32'(in_ready), 32'd0);
        check("cm_we", 32'(rf_write_en), 32'd1);
        check("cm_addr", 32'(rf_write_addr), 32'd0);
        check("cm_data", 32'(rf_write_data), 32'h0707);
        tick(); beat(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0); mid();
        check("cm_busy", 32'(clear_busy), 32'd1);
        check("cm_c0_addr", 32'(rf_write_addr), 32'd0);
        check("cm_c0_data", 32'(rf_write_data), 32'd0);
        tick(); clear_req = 1'b0; mid();
        check("cm_c1_we", 32'(rf_write_en), 32'd1);
        check("cm_c1_addr", 32'(rf_write_addr), 32'd1);
        tick(); mid();
        check("cm_run_busy", 32'(clear_busy), 32'd0);
        check("cm_run_we", 32'(rf_write_en), 32'd0);
        check("cm_mem1", 32'(mem[1]), 32'd0);

        // Reset with a beat in flight: no write, no row_done, clear restarts at row 0
        tick(); beat(1'b1, 1'b0, 16'h0909, 1'b1, 1'b1);
        tick(); beat(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0); rst = 1'b1; mid();
        check("mr_we", 32'(rf_write_en), 32'd0);
        tick(); rst = 1'b0; mid();
        check("mr_busy", 32'(clear_busy), 32'd1);
        check("mr_clr_addr", 32'(rf_write_addr), 32'd0);
        check("mr_rowdone", 32'(row_done), 32'd0);
        check("mr_mem0", 32'(mem[0]), 32'd0);
        tick(); tick(); mid();
        check("mr_ready", 32'(in_ready), 32'd1);

        // Out-of-range row on the three-row instance
        tick();
        b_in_valid = 1'b1; b_in_addr = 2'd3; b_in_data = 16'h0101;
        b_in_first = 1'b0; b_in_last = 1'b1;
        mid();
        check("oor_ready", 32'(b_in_ready), 32'd1);
        check("oor_read_en", 32'(b_rf_read_en), 32'd0);
        tick(); b_in_addr = 2'd2; mid();
        check("oor_we", 32'(b_rf_write_en), 32'd0);
        check("inr_read_en", 32'(b_rf_read_en), 32'd1);
        check("inr_read_addr", 32'(b_rf_read_addr), 32'd2);
        tick(); b_in_valid = 1'b0; b_in_last = 1'b0; mid();
        check("oor_rowdone", 32'(b_row_done), 32'd0);
        check("inr_we", 32'(b_rf_write_en), 32'd1);
        check("inr_waddr", 32'(b_rf_write_addr), 32'd2);
        tick(); mid();
        check("inr_rowdone", 32'(b_row_done), 32'd1);
        check("inr_rowdone_addr", 32'(b_row_done_addr), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Read-modify-write controller directly upstream of the CONV partial-sum register file (out_regfile).
- Accepts one beat of Pout partial products per cycle with a row address.
- Reads the stored partial sums through the register file read port, adds the new products lane-wise, and writes the result back through the write port.
- Also zero-initialises the register file, which has no reset, after reset and on request.

Parameters:
- Nout, 3, number of output feature maps (register file depth in elements).
- Pout, 2, output parallelism (lanes per beat and per register file row).
- BIT_WIDTH, 8, element width; elements are two's-complement signed.
- ADDR_W (localparam), clog2(ceil_div(Nout,Pout)), row address width.
- NADDR (localparam), ceil_div(Nout,Pout), number of rows.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid and in_ready are both high.
- in_addr  in  ADDR_W  target row.
- in_data  in  Pout*BIT_WIDTH  partial products, lane i at [i*BIT_WIDTH+:BIT_WIDTH].
- in_first  in  1  start a new accumulation: stored value is treated as 0.
- in_last  in  1  final beat for this row.
- clear_req  in  1  request to zero all rows.
- rf_read_en  out  1  to register file read_en.
- rf_read_addr  out  ADDR_W  to register file read_addr.
- rf_read_data  in  Pout*BIT_WIDTH  from register file; registered, valid 1 cycle after rf_read_en.
- rf_write_en  out  1  to register file write_en.
- rf_write_addr  out  ADDR_W  to register file write_addr.
- rf_write_data  out  Pout*BIT_WIDTH  to register file write_data.
- row_done  out  1  one-cycle pulse when an in_last beat is written.
- row_done_addr  out  ADDR_W  row associated with row_done.
- clear_busy  out  1  high while in CLEAR.

Behaviour:
- Clocking and reset: one clock, clk. Synchronous active-high reset rst.
- Reset values: state=CLEAR, clear counter=0, s1_valid=0, row_done=0, row_done_addr=0. clear_busy=1 immediately after reset.
- FSM states:
  - CLEAR: rf_write_en=1, rf_write_addr=cnt, rf_write_data=0. cnt increments each cycle. At cnt==NADDR-1, go to RUN and reset cnt to 0. Lasts exactly NADDR cycles.
  - RUN: normal accumulation. clear_req sampled high in RUN moves to CLEAR on the next cycle.
- clear_req while in CLEAR is ignored (no restart).
- in_ready = (state==RUN) && !clear_req. It is combinational.
- Stage 0, accept cycle t:
  - rf_read_en = accept && !in_first; rf_read_addr = in_addr. Both combinational.
  - Register s1_valid, addr, data, first, last.
- Stage 1, cycle t+1:
  - Per lane: sum = (s1_first ? 0 : rf_read_data lane) + s1_data lane.
  - rf_write_en = s1_valid; write_addr and write_data are combinational from the stage-1 registers.
- Throughput and latency:
  - Back-to-back beats to the same row are correct: the read at t+1 coincides with the write at t+1, and the register file forwards write_data.
  - Throughput is 1 beat/cycle. Latency from accept to write is 1 cycle.
- Write-port arbitration: clear_req drops in_ready in the same cycle, so a beat in flight writes before CLEAR begins. No write-port conflict is possible.
- in_addr >= NADDR: beat is accepted and dropped. No read, no write, no row_done.
- Lanes beyond Nout in the last row are computed normally; the register file ignores them.
- row_done: registered pulse at t+2 for an accepted in_last beat. row_done_addr holds its value until the next pulse.
- in_first and in_last both high on one beat: plain write of in_data, then row_done.
- Reset mid-operation: in-flight beat discarded, no write; FSM restarts CLEAR from row 0.
- Arithmetic: signed BIT_WIDTH add. Result truncated modulo 2^BIT_WIDTH (wrap) unless the optional feature is enabled.

Optional Feature:
- Macro PSUM_SATURATE_EN.
- Defined: signed saturating add per lane, result clamped to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
- Undefined: wrapping add; no overflow logic is synthesised.

Decomposition:
- Shared include: clog2 and ceil_div from functions.v. Shared package constants: ADDR_W, NADDR, and FSM state encoding (CLEAR=1'b0, RUN=1'b1).
- One sub-module: psum_lane_add (BIT_WIDTH in, macro-dependent wrap/saturate). Instantiated Pout times in a generate loop.

Test Plan (Nout=3, Pout=2, BIT_WIDTH=8, paired with out_regfile):
- Post-reset clear: rst for 1 cycle, then idle -> rf_write_en high for 2 cycles with addr 0,1 and data 0; in_ready low for those cycles then high; regfile output = 0.
- Accumulate: beats to addr0 {first, lanes 3,5}, {2,-1}, {last, 1,1} back-to-back -> rows hold 6,5; row_done pulses once with addr 0, 2 cycles after the last accept.
- Same-address hazard: alternate addr0/addr0/addr1/addr0, each lane +1 after a first beat of 0 -> addr0 lanes =3, addr1 lanes =1 (forwarding exercised).
- Overflow: addr1 first 100, then +100 -> wrap build gives -56 (0xC8); PSUM_SATURATE_EN build gives 127. Adding -100 twice from -100 gives 56 (wrap) or -128 (saturate).
- Clear mid-stream: clear_req pulsed the cycle after a beat is accepted -> that beat's write occurs, then 2 clear writes, then RUN; a beat presented during clear_req is not accepted.
- Out-of-range address: in_addr=2 (NADDR=2) -> accepted, no rf_read_en/rf_write_en, no row_done.
